// File: rtl/l3_cache_responder.sv
// Direct-mapped write-back L3 line store answering L2 reads and write-backs, backed by main memory.
// Hits pulse L3_ready/verified two cycles after the IDLE sample; misses stall on mem_ready handshakes.
module l3_cache_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int INDEX_BITS    = 4,
    parameter int OFFSET_BITS   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     read_from_L3_request,
    input  logic                     write_back_to_L3_request,
    input  logic [ADDRESS_WIDTH-1:0] cache_L3_memory_address,
    input  logic [LINE_WIDTH-1:0]    write_back_to_L3_data,
    output logic                     L3_ready,
    output logic [LINE_WIDTH-1:0]    write_data_to_L2_from_L3,
    output logic                     write_back_to_L3_verified,
    output logic                     mem_read_request,
    output logic                     mem_write_request,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0]    mem_write_data,
    input  logic [LINE_WIDTH-1:0]    mem_read_data,
    input  logic                     mem_ready,
    output logic [15:0]              L3_hit_count,
    output logic [15:0]              L3_miss_count
);

    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESPOND} state_t;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:OFFSET_BITS] line_addr_q;
    logic [LINE_WIDTH-1:0]              wdata_q;
    logic                               is_wb_q;

    logic [LINES-1:0]      valid_q, dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [LINE_WIDTH-1:0] line_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit, victim_dirty, take_req;
    logic                  line_we;
    logic [LINE_WIDTH-1:0] line_wdat;

    logic                     l3_ready_q, l3_ready_d;
    logic [LINE_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                     verified_q, verified_d;
    logic                     mem_rd_q, mem_rd_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [15:0]              hit_cnt_q, hit_cnt_d;
    logic [15:0]              miss_cnt_q, miss_cnt_d;

    // Byte offset within a line never influences behaviour.
    logic unused_offset;
    assign unused_offset = ^cache_L3_memory_address[OFFSET_BITS-1:0];

    assign idx          = line_addr_q[OFFSET_BITS +: INDEX_BITS];
    assign req_tag      = line_addr_q[ADDRESS_WIDTH-1 -: TAG_BITS];
    assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];
    assign take_req     = (state_q == IDLE) && (read_from_L3_request || write_back_to_L3_request);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_req) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)               state_d = RESPOND;
                else if (victim_dirty) state_d = EVICT;
                else if (is_wb_q)      state_d = RESPOND;
                else                   state_d = FILL;
            end
            EVICT:   if (mem_ready) state_d = is_wb_q ? RESPOND : FILL;
            FILL:    if (mem_ready) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the upcoming state.
    always_comb begin
        l3_ready_d  = (state_d == RESPOND) && !is_wb_q;
        verified_d  = (state_d == RESPOND) && is_wb_q;
        rd_data_d   = '0;
        if (l3_ready_d) begin
            rd_data_d = (state_q == FILL) ? mem_read_data : line_q[idx];
        end
        mem_rd_d    = (state_d == FILL);
        mem_wr_d    = (state_d == EVICT);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (mem_wr_d) begin
            mem_addr_d  = {tag_q[idx], idx, {OFFSET_BITS{1'b0}}};
            mem_wdata_d = line_q[idx];
        end else if (mem_rd_d) begin
            mem_addr_d  = {req_tag, idx, {OFFSET_BITS{1'b0}}};
        end
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit && (hit_cnt_q != 16'hFFFF))    hit_cnt_d  = hit_cnt_q + 16'd1;
            if (!hit && (miss_cnt_q != 16'hFFFF))  miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l3_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            verified_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            l3_ready_q  <= l3_ready_d;
            rd_data_q   <= rd_data_d;
            verified_q  <= verified_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_addr_q <= '0;
            wdata_q     <= '0;
            is_wb_q     <= 1'b0;
        end else if (take_req) begin
            line_addr_q <= cache_L3_memory_address[ADDRESS_WIDTH-1:OFFSET_BITS];
            wdata_q     <= write_back_to_L3_data;
            is_wb_q     <= write_back_to_L3_request;
        end
    end

    // A write-back writes the whole line, so it installs without a fill once any dirty victim is gone.
    always_comb begin
        line_we   = 1'b0;
        line_wdat = wdata_q;
        case (state_q)
            LOOKUP:  line_we = is_wb_q && (hit || !victim_dirty);
            EVICT:   line_we = is_wb_q && mem_ready;
            FILL: begin
                line_we   = mem_ready;
                line_wdat = mem_read_data;
            end
            default: line_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[idx] <= line_wdat;
            tag_q[idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= is_wb_q;
        end else if ((state_q == EVICT) && mem_ready) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    assign L3_ready                  = l3_ready_q;
    assign write_data_to_L2_from_L3  = rd_data_q;
    assign write_back_to_L3_verified = verified_q;
    assign mem_read_request          = mem_rd_q;
    assign mem_write_request         = mem_wr_q;
    assign mem_address               = mem_addr_q;
    assign mem_write_data            = mem_wdata_q;
    assign L3_hit_count              = hit_cnt_q;
    assign L3_miss_count             = miss_cnt_q;

endmodule

// File: tb/tb_l3_cache_responder.sv
// Scoreboard bench for l3_cache_responder: a cache/memory reference model predicts pulses and memory traffic.
module tb_l3_cache_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_from_L3_request;
    logic         write_back_to_L3_request;
    logic [31:0]  cache_L3_memory_address;
    logic [127:0] write_back_to_L3_data;
    logic         L3_ready;
    logic [127:0] write_data_to_L2_from_L3;
    logic         write_back_to_L3_verified;
    logic         mem_read_request;
    logic         mem_write_request;
    logic [31:0]  mem_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;
    logic         mem_ready;
    logic [15:0]  L3_hit_count;
    logic [15:0]  L3_miss_count;

    always #5 clk = ~clk;

    l3_cache_responder #(
        .ADDRESS_WIDTH(32), .LINE_WIDTH(128), .INDEX_BITS(4), .OFFSET_BITS(4)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .read_from_L3_request      (read_from_L3_request),
        .write_back_to_L3_request  (write_back_to_L3_request),
        .cache_L3_memory_address   (cache_L3_memory_address),
        .write_back_to_L3_data     (write_back_to_L3_data),
        .L3_ready                  (L3_ready),
        .write_data_to_L2_from_L3  (write_data_to_L2_from_L3),
        .write_back_to_L3_verified (write_back_to_L3_verified),
        .mem_read_request          (mem_read_request),
        .mem_write_request         (mem_write_request),
        .mem_address               (mem_address),
        .mem_write_data            (mem_write_data),
        .mem_read_data             (mem_read_data),
        .mem_ready                 (mem_ready),
        .L3_hit_count              (L3_hit_count),
        .L3_miss_count             (L3_miss_count)
    );

    typedef struct { bit is_wb; logic [127:0] data; } rsp_t;
    typedef struct { bit is_write; logic [31:0] addr; logic [127:0] data; } mop_t;

    rsp_t exp_rsp_q[$];
    mop_t exp_mem_q[$];

    int checks = 0;
    int errors = 0;
    int mem_lat = 3;
    bit mem_hold = 1'b0;

    // Reference model: cache contents as plain arrays plus a sparse picture of main memory.
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [23:0]  m_tag   [16];
    logic [127:0] m_data  [16];
    int           m_hits = 0;
    int           m_misses = 0;
    logic [127:0] ref_mem   [logic [31:0]];
    logic [127:0] mem_store [logic [31:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [127:0] default_line(input logic [31:0] la);
        if (la == 32'h0000_0100) return {32{4'hA}};
        return {la ^ 32'h5A5A_0000, ~la, la, 32'hC0DE_0000 | {16'h0, la[15:0]}};
    endfunction

    function automatic logic [127:0] ref_read(input logic [31:0] la);
        if (ref_mem.exists(la)) return ref_mem[la];
        return default_line(la);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_txn(input bit is_wb, input logic [31:0] addr, input logic [127:0] data,
                             output bit hit);
        logic [31:0] la;
        logic [23:0] tg;
        int          ix;
        la  = {addr[31:4], 4'h0};
        tg  = la[31:8];
        ix  = int'(la[7:4]);
        hit = m_valid[ix] && (m_tag[ix] == tg);
        if (hit) begin
            if (m_hits < 65535) m_hits++;
            if (is_wb) begin
                m_data[ix]  = data;
                m_dirty[ix] = 1'b1;
                exp_rsp_q.push_back('{1'b1, 128'h0});
            end else begin
                exp_rsp_q.push_back('{1'b0, m_data[ix]});
            end
        end else begin
            if (m_misses < 65535) m_misses++;
            if (m_valid[ix] && m_dirty[ix]) begin
                exp_mem_q.push_back('{1'b1, {m_tag[ix], la[7:4], 4'h0}, m_data[ix]});
                ref_mem[{m_tag[ix], la[7:4], 4'h0}] = m_data[ix];
            end
            m_tag[ix]   = tg;
            m_valid[ix] = 1'b1;
            if (is_wb) begin
                m_data[ix]  = data;
                m_dirty[ix] = 1'b1;
                exp_rsp_q.push_back('{1'b1, 128'h0});
            end else begin
                m_data[ix]  = ref_read(la);
                m_dirty[ix] = 1'b0;
                exp_mem_q.push_back('{1'b0, la, 128'h0});
                exp_rsp_q.push_back('{1'b0, m_data[ix]});
            end
        end
    endtask

    // Main-memory responder: checks each request against the predicted traffic, answers after mem_lat.
    initial begin
        mop_t         e;
        logic [31:0]  cur_addr;
        logic [127:0] cur_wdata;
        bit           cur_wr;
        mem_ready     = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            while (!reset && (mem_read_request || mem_write_request)) begin
                if (exp_mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got rd=%b wr=%b addr=%h, required no memory request",
                             mem_read_request, mem_write_request, mem_address);
                end else begin
                    e = exp_mem_q.pop_front();
                    chk("mem_is_write", 128'(mem_write_request), 128'(e.is_write));
                    chk("mem_address", 128'(mem_address), 128'(e.addr));
                    if (e.is_write) chk("mem_write_data", mem_write_data, e.data);
                end
                cur_addr  = mem_address;
                cur_wr    = mem_write_request;
                cur_wdata = mem_write_data;
                repeat (mem_lat) @(negedge clk);
                if (mem_hold) begin
                    while (mem_hold) @(negedge clk);
                end else begin
                    chk("mem_req_held", 128'(cur_wr ? mem_write_request : mem_read_request), 128'(1));
                    if (cur_wr) begin
                        mem_store[cur_addr] = cur_wdata;
                        mem_read_data = '0;
                    end else begin
                        mem_read_data = mem_store.exists(cur_addr) ? mem_store[cur_addr] : default_line(cur_addr);
                    end
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    chk("mem_req_dropped", 128'(cur_wr ? mem_write_request : mem_read_request), 128'(0));
                end
            end
        end
    end

    // Response monitor: every pulse must match the oldest predicted response.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!reset && (L3_ready || write_back_to_L3_verified)) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got ready=%b verified=%b, required no pulse",
                             L3_ready, write_back_to_L3_verified);
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_verified", 128'(write_back_to_L3_verified), 128'(r.is_wb));
                    chk("rsp_ready", 128'(L3_ready), 128'(!r.is_wb));
                    if (!r.is_wb) chk("rsp_data", write_data_to_L2_from_L3, r.data);
                end
            end
            if (mem_read_request && mem_write_request) begin
                checks++;
                errors++;
                $display("FAIL mem_both_requests: got rd=1 wr=1, required at most one");
            end
        end
    end

    task automatic wait_pulse(input bit want_wb, inout int cyc);
        bit seen;
        seen = 1'b0;
        while (!seen) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            seen = want_wb ? write_back_to_L3_verified : L3_ready;
            if (!seen && cyc > 200) begin
                errors++;
                $display("FAIL pulse_timeout: got no pulse after %0d cycles, required a pulse", cyc);
                finish_sim();
            end
        end
    endtask

    task automatic end_checks();
        chk("hit_count", 128'(L3_hit_count), 128'(m_hits));
        chk("miss_count", 128'(L3_miss_count), 128'(m_misses));
        @(posedge clk);
        #1;
        chk("rsp_drained", 128'(exp_rsp_q.size()), 128'(0));
        chk("mem_drained", 128'(exp_mem_q.size()), 128'(0));
    endtask

    task automatic single(input bit is_wb, input logic [31:0] addr, input logic [127:0] data);
        bit hit;
        int cyc;
        model_txn(is_wb, addr, data, hit);
        cache_L3_memory_address  = addr;
        write_back_to_L3_data    = data;
        read_from_L3_request     = !is_wb;
        write_back_to_L3_request = is_wb;
        @(posedge clk);
        #1;
        // Captured values must be used; scramble the live inputs once the request is sampled.
        cache_L3_memory_address = $urandom();
        write_back_to_L3_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyc = 1;
        wait_pulse(is_wb, cyc);
        read_from_L3_request     = 1'b0;
        write_back_to_L3_request = 1'b0;
        if (hit) chk("hit_latency", 128'(cyc), 128'(2));
        end_checks();
    endtask

    task automatic dual(input logic [31:0] rd_addr, input logic [31:0] wb_addr, input logic [127:0] wb_data);
        bit hit;
        int cyc;
        model_txn(1'b1, wb_addr, wb_data, hit);
        model_txn(1'b0, rd_addr, 128'h0, hit);
        cache_L3_memory_address  = wb_addr;
        write_back_to_L3_data    = wb_data;
        read_from_L3_request     = 1'b1;
        write_back_to_L3_request = 1'b1;
        cyc = 0;
        wait_pulse(1'b1, cyc);
        write_back_to_L3_request = 1'b0;
        cache_L3_memory_address  = rd_addr;
        cyc = 0;
        wait_pulse(1'b0, cyc);
        read_from_L3_request = 1'b0;
        end_checks();
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion, required completion");
        finish_sim();
    end

    initial begin
        bit           hit;
        int           n;
        logic [31:0]  a, b;
        logic [127:0] d;
        reset                    = 1'b1;
        read_from_L3_request     = 1'b0;
        write_back_to_L3_request = 1'b0;
        cache_L3_memory_address  = '0;
        write_back_to_L3_data    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(L3_ready), 128'(0));
        chk("rst_verified", 128'(write_back_to_L3_verified), 128'(0));
        chk("rst_mem_rd", 128'(mem_read_request), 128'(0));
        chk("rst_mem_wr", 128'(mem_write_request), 128'(0));
        chk("rst_mem_addr", 128'(mem_address), 128'(0));
        chk("rst_hits", 128'(L3_hit_count), 128'(0));
        chk("rst_misses", 128'(L3_miss_count), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        mem_lat = 3;
        single(1'b0, 32'h0000_0100, 128'h0);
        single(1'b0, 32'h0000_0104, 128'h0);
        single(1'b1, 32'h0000_0100, {32{4'h1}});
        single(1'b0, 32'h0000_0100, 128'h0);
        single(1'b0, 32'h0000_0200, 128'h0);
        dual(32'h0000_0300, 32'h0000_0400, {32{4'h7}});

        // Reset while the fill for 0x500 is outstanding.
        mem_hold = 1'b1;
        model_txn(1'b0, 32'h0000_0500, 128'h0, hit);
        cache_L3_memory_address = 32'h0000_0500;
        read_from_L3_request    = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read_request && n < 50);
        chk("fill_started", 128'(mem_read_request), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_fill_ready", 128'(L3_ready), 128'(0));
        chk("rst_fill_mem_rd", 128'(mem_read_request), 128'(0));
        chk("rst_fill_mem_addr", 128'(mem_address), 128'(0));
        chk("rst_fill_hits", 128'(L3_hit_count), 128'(0));
        chk("rst_fill_misses", 128'(L3_miss_count), 128'(0));
        read_from_L3_request = 1'b0;
        exp_rsp_q.delete();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        mem_hold = 1'b0;
        chk("rst_no_pulse", 128'(exp_rsp_q.size()), 128'(0));
        chk("rst_mem_consumed", 128'(exp_mem_q.size()), 128'(0));
        @(posedge clk);
        #1;
        single(1'b0, 32'h0000_0100, 128'h0);

        for (int i = 0; i < 150; i++) begin
            mem_lat = $urandom_range(1, 4);
            a = {20'h0, 4'($urandom_range(1, 4)), 4'($urandom_range(0, 15)), 4'($urandom())};
            b = {20'h0, 4'($urandom_range(1, 4)), 4'($urandom_range(0, 15)), 4'($urandom())};
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 9) == 0) dual(b, a, d);
            else                           single($urandom_range(0, 2) == 0, a, d);
        end
        finish_sim();
    end

endmodule

// File: doc/l3_cache_responder.md
# l3_cache_responder

Responder end of the L2→L3 link: services line reads and dirty-line write-backs issued by an L2 cache controller, answering with `L3_ready` plus line data or `write_back_to_L3_verified`. It holds a direct-mapped, write-back L3 line store. It fetches from and evicts to main memory through a request/ready handshake. It sits between the L2 cache FSMs and the main memory model.

## Interface
- `ADDRESS_WIDTH`, 32: byte address width.
- `LINE_WIDTH`, 128: line width in bits; matches `MAIN_MEMORY_DATA_WIDTH`.
- `INDEX_BITS`, 4: log2 of the line count (16 lines).
- `OFFSET_BITS`, 4: byte-offset bits within a line. Tag = `addr[ADDRESS_WIDTH-1:OFFSET_BITS+INDEX_BITS]`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `read_from_L3_request` in 1: L2 line-read request, level; held until `L3_ready`.
- `write_back_to_L3_request` in 1: L2 write-back request, level; held until `write_back_to_L3_verified`.
- `cache_L3_memory_address` in ADDRESS_WIDTH: request address; offset bits ignored.
- `write_back_to_L3_data` in LINE_WIDTH: full line being written back.
- `L3_ready` out 1: one-cycle pulse; read complete.
- `write_data_to_L2_from_L3` out LINE_WIDTH: read line, valid while `L3_ready`=1.
- `write_back_to_L3_verified` out 1: one-cycle pulse; write-back absorbed.
- `mem_read_request` out 1: main-memory line read, level.
- `mem_write_request` out 1: main-memory line write, level.
- `mem_address` out ADDRESS_WIDTH: line-aligned memory address (offset bits 0).
- `mem_write_data` out LINE_WIDTH: eviction data.
- `mem_read_data` in LINE_WIDTH: fill data, valid when `mem_ready`=1.
- `mem_ready` in 1: one-cycle pulse completing the current memory request.
- `L3_hit_count`, `L3_miss_count` out 16 each: saturating event counters.

## Operation
- States: IDLE, LOOKUP, EVICT, FILL, RESPOND.
- IDLE samples the requests and captures address, data and request type into registers. If both requests are high, the write-back wins; the read stays pending and is taken on a later IDLE visit. With no request, the FSM stays in IDLE.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit → RESPOND.
  - Write-back hit → overwrite the line, set dirty → RESPOND.
  - Miss with the victim valid and dirty → EVICT.
  - Other misses: a read goes to FILL. A write-back installs the line directly (full-line write, no fill), sets valid and dirty, then goes to RESPOND.
  - Each lookup increments exactly one counter. Both counters saturate at 0xFFFF.
- EVICT: `mem_write_request`=1. `mem_address` = {victim tag, index, 0}. `mem_write_data` = victim line.
  - On `mem_ready`: clear dirty, drop the request.
  - Next state is FILL (read) or direct install → RESPOND (write-back).
- FILL: `mem_read_request`=1 with the line-aligned request address. On `mem_ready`: store `mem_read_data`, set valid, clear dirty, drop the request → RESPOND.
- RESPOND: pulse `L3_ready` with the line (read) or `write_back_to_L3_verified` (write-back) → IDLE.
- The requester must drop its request in the cycle after the pulse. The responder re-samples only in IDLE.
- Request inputs are ignored outside IDLE. Captured values are used, so input changes mid-transaction have no effect.

## Timing
- Every output is a register. All outputs, both counters, and all valid/dirty bits reset to 0. Line data is not reset.
- Read or write-back hit: request seen in IDLE at edge k; pulse is high in cycle k+2.
- Miss: the pulse comes in the cycle after the final `mem_ready` is registered. At most one memory request is high at a time, and EVICT always completes before FILL begins.
- `mem_*_request` remains high until the edge that samples `mem_ready`=1, then falls.
- Reset mid-transaction returns to IDLE immediately and drops any memory request. The interrupted transaction is lost and produces no pulse.

## Test plan
- **Cold read miss:** reset, then read 0x0000_0100.
  - Required: `mem_read_request` with `mem_address`=0x0000_0100. Memory returns 0xAAAA…AAAA after 3 cycles.
  - Required: one `L3_ready` pulse with that data; `L3_miss_count`=1.
- **Read hit:** read 0x0000_0104 after the cold miss. Required: `L3_ready` exactly 2 cycles after the request, data 0xAAAA…AAAA, no memory activity, `L3_hit_count`=1.
- **Write-back hit:** write back 0x0000_0100 with 0x1111…1111.
  - Required: `write_back_to_L3_verified` at +2 cycles, no memory activity.
  - Required: a following read of 0x0000_0100 returns 0x1111…1111.
- **Dirty conflict:** read 0x0000_0200 (index 0, dirty victim).
  - Required: `mem_write_request` for 0x0000_0100 with 0x1111…1111 first.
  - Required: then `mem_read_request` for 0x0000_0200, then `L3_ready`.
- **Simultaneous requests:** assert read 0x0000_0300 and write-back 0x0000_0400 in the same cycle. Required: the write-back is verified first; the read is served on the next IDLE visit.
- **Reset in FILL:** assert reset while in FILL.
  - Required: all outputs 0 at once, `mem_read_request` low, counters 0.
  - Required: a later read of 0x0000_0100 is a miss.
